// File: rtl/voice_alloc.sv
// voice_alloc: scans the held-key vector one key per cycle, detects note-on /
// note-off edges against a snapshot, and maps keys onto a small pool of
// oscillator voices. When every voice is busy, voices are stolen round-robin.
`ifndef NKEYS
`define NKEYS 128
`endif

module voice_alloc #(
  parameter int NKEYS   = `NKEYS,
  parameter int NVOICES = 4,
  parameter int KW      = 7
) (
  input  logic                  clk25,
  input  logic                  rst,
  input  logic [NKEYS-1:0]      key_status,
  output logic [NVOICES-1:0]    voice_active,
  output logic [NVOICES*KW-1:0] voice_key,
  output logic [NVOICES-1:0]    voice_trig,
  output logic                  steal
);

  localparam int SW = (NVOICES > 1) ? $clog2(NVOICES) : 1;

  logic [KW-1:0]         scan_idx_q,     scan_idx_d;
  logic [SW-1:0]         steal_ptr_q,    steal_ptr_d;
  logic [NKEYS-1:0]      prev_status_q,  prev_status_d;
  logic [NVOICES-1:0]    voice_active_q, voice_active_d;
  logic [NVOICES*KW-1:0] voice_key_q,    voice_key_d;
  logic [NVOICES-1:0]    voice_trig_q,   voice_trig_d;
  logic                  steal_q,        steal_d;

  logic          key_now;
  logic          key_was;
  logic          note_on;
  logic          note_off;
  logic          free_found;
  logic [SW-1:0] free_idx;

  // Edge detection for the single key under the scan pointer this cycle.
  always_comb begin
    key_now  = key_status[scan_idx_q];
    key_was  = prev_status_q[scan_idx_q];
    note_on  = key_now & ~key_was;
    note_off = ~key_now & key_was;
  end

  // Lowest-numbered inactive voice; searching downward leaves the lowest hit.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    free_found = 1'b0;
    free_idx   = '0;
    for (int v = NVOICES - 1; v >= 0; v--) begin
      if (!voice_active_q[v]) begin
        free_found = 1'b1;
        free_idx   = SW'(v);
      end
    end
  end

  // Next-state: advance scan, update snapshot, apply at most one key event.
  always_comb begin
    scan_idx_d     = (scan_idx_q == KW'(NKEYS - 1)) ? '0 : scan_idx_q + 1'b1;
    prev_status_d  = prev_status_q;
    prev_status_d[scan_idx_q] = key_now;
    steal_ptr_d    = steal_ptr_q;
    voice_active_d = voice_active_q;
    voice_key_d    = voice_key_q;
    voice_trig_d   = '0;
    steal_d        = 1'b0;

    if (note_on) begin
      if (free_found) begin
        voice_active_d[free_idx]          = 1'b1;
        voice_key_d[free_idx*KW +: KW]    = scan_idx_q;
        voice_trig_d[free_idx]            = 1'b1;
      end else begin
        voice_key_d[steal_ptr_q*KW +: KW] = scan_idx_q;
        voice_trig_d[steal_ptr_q]         = 1'b1;
        steal_d                           = 1'b1;
        steal_ptr_d = (steal_ptr_q == SW'(NVOICES - 1)) ? '0 : steal_ptr_q + 1'b1;
      end
    end else if (note_off) begin
      // Key number is kept so the release envelope retains its pitch; a
      // stolen key finds no match here and is silently dropped.
      for (int v = 0; v < NVOICES; v++) begin
        if (voice_active_q[v] && (voice_key_q[v*KW +: KW] == scan_idx_q)) begin
          voice_active_d[v] = 1'b0;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk25) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      scan_idx_q     <= '0;
      steal_ptr_q    <= '0;
      // NOTE: the snapshot is cleared on reset (not left as plain storage) so
      // keys still held afterwards re-trigger as fresh note-ons.
      prev_status_q  <= '0;
      voice_active_q <= '0;
      voice_key_q    <= '0;
      voice_trig_q   <= '0;
      steal_q        <= 1'b0;
    end else begin
      scan_idx_q     <= scan_idx_d;
      steal_ptr_q    <= steal_ptr_d;
      prev_status_q  <= prev_status_d;
      voice_active_q <= voice_active_d;
      voice_key_q    <= voice_key_d;
      voice_trig_q   <= voice_trig_d;
      steal_q        <= steal_d;
    end
  end

  assign voice_active = voice_active_q;
  assign voice_key    = voice_key_q;
  assign voice_trig   = voice_trig_q;
  assign steal        = steal_q;

endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc: reset, single note, release, chord,
// glitch rejection, round-robin stealing and reset during play.
module tb_voice_alloc;

  logic         clk25 = 1'b0;
  logic         rst   = 1'b1;
  logic [127:0] key_status = '0;
  logic [3:0]   voice_active;
  logic [27:0]  voice_key;
  logic [3:0]   voice_trig;
  logic         steal;

  int checks = 0;
  int errors = 0;

  // Pulse counters: cycles each trig bit / steal was high.
  int trig_cnt [4] = '{0, 0, 0, 0};
  int steal_cnt    = 0;
  int base_trig[4];
  int base_steal;

  voice_alloc dut (
    .clk25        (clk25),
    .rst          (rst),
    .key_status   (key_status),
    .voice_active (voice_active),
    .voice_key    (voice_key),
    .voice_trig   (voice_trig),
    .steal        (steal)
  );

  always #20 clk25 = ~clk25;

  // Count output pulses shortly after every active edge.
  always @(posedge clk25) begin
    #1;
    for (int v = 0; v < 4; v++) if (voice_trig[v] === 1'b1) trig_cnt[v]++;
    if (steal === 1'b1) steal_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] vk(input int v);
    return voice_key[v*7 +: 7];
  endfunction

  task automatic run(input int n);
    repeat (n) @(negedge clk25);
  endtask

  task automatic snap();
    for (int v = 0; v < 4; v++) base_trig[v] = trig_cnt[v];
    base_steal = steal_cnt;
  endtask

  task automatic check_pulses(input string tag, input int t0, input int t1,
                              input int t2, input int t3, input int s);
    check({tag, "_trig0"}, 64'(trig_cnt[0] - base_trig[0]), 64'(t0));
    check({tag, "_trig1"}, 64'(trig_cnt[1] - base_trig[1]), 64'(t1));
    check({tag, "_trig2"}, 64'(trig_cnt[2] - base_trig[2]), 64'(t2));
    check({tag, "_trig3"}, 64'(trig_cnt[3] - base_trig[3]), 64'(t3));
    check({tag, "_steal"}, 64'(steal_cnt - base_steal), 64'(s));
  endtask

  // Two reset edges with random keys, then release with the given keys.
  task automatic do_reset(input logic [127:0] keys_after);
    @(negedge clk25);
    rst = 1'b1;
    key_status = {$urandom, $urandom, $urandom, $urandom};
    run(2);
    key_status = keys_after;
    rst = 1'b0;
  endtask

  initial begin
    logic [127:0] k;

    // Reset with random keys: all outputs and scan index cleared.
    do_reset('0);
    check("rst_active", 64'(voice_active), 64'h0);
    check("rst_key",    64'(voice_key),    64'h0);
    check("rst_trig",   64'(voice_trig),   64'h0);
    check("rst_steal",  64'(steal),        64'h0);
    check("rst_scan",   64'(dut.scan_idx_q), 64'h0);
    snap();
    run(130);
    check("idle_active", 64'(voice_active), 64'h0);
    check_pulses("idle", 0, 0, 0, 0, 0);

    // Single note 60.
    snap();
    k = '0; k[60] = 1'b1; key_status = k;
    run(130);
    check("one_active", 64'(voice_active), 64'h1);
    check("one_key0",   64'(vk(0)),        64'd60);
    check_pulses("one", 1, 0, 0, 0, 0);

    // Release key 60: gate drops, pitch retained, no trigger.
    snap();
    key_status = '0;
    run(130);
    check("rel_active", 64'(voice_active), 64'h0);
    check("rel_key0",   64'(vk(0)),        64'd60);
    check_pulses("rel", 0, 0, 0, 0, 0);

    // Chord 67/64/60 from a fresh scan: assigned in scan order.
    k = '0; k[60] = 1'b1; k[64] = 1'b1; k[67] = 1'b1;
    do_reset(k);
    snap();
    run(130);
    check("chord_active", 64'(voice_active), 64'h7);
    check("chord_key0",   64'(vk(0)),        64'd60);
    check("chord_key1",   64'(vk(1)),        64'd64);
    check("chord_key2",   64'(vk(2)),        64'd67);
    check_pulses("chord", 1, 1, 1, 0, 0);

    // Key 100 toggles on and off before the scan reaches it: no event.
    do_reset('0);
    snap();
    k = '0; k[100] = 1'b1; key_status = k;
    run(10);
    key_status = '0;
    run(130);
    check("glitch_active", 64'(voice_active), 64'h0);
    check_pulses("glitch", 0, 0, 0, 0, 0);

    // Fill all voices with 10/20/30/40.
    k = '0; k[10] = 1'b1; k[20] = 1'b1; k[30] = 1'b1; k[40] = 1'b1;
    do_reset(k);
    run(130);
    check("fill_active", 64'(voice_active), 64'hF);
    check("fill_key3",   64'(vk(3)),        64'd40);

    // Key 50 steals voice 0.
    snap();
    k[50] = 1'b1; key_status = k;
    run(130);
    check("steal_active", 64'(voice_active), 64'hF);
    check("steal_key0",   64'(vk(0)),        64'd50);
    check("steal_key1",   64'(vk(1)),        64'd20);
    check_pulses("steal", 1, 0, 0, 0, 1);

    // Releasing stolen key 10 changes nothing.
    snap();
    k[10] = 1'b0; key_status = k;
    run(130);
    check("orphan_active", 64'(voice_active), 64'hF);
    check("orphan_keys",   64'(voice_key),
          64'({7'd40, 7'd30, 7'd20, 7'd50}));
    check_pulses("orphan", 0, 0, 0, 0, 0);

    // Steal pointer advances 1,2,3 then wraps back to 0.
    snap();
    k[70] = 1'b1; key_status = k; run(130);
    check("rr_key1", 64'(vk(1)), 64'd70);
    k[80] = 1'b1; key_status = k; run(130);
    check("rr_key2", 64'(vk(2)), 64'd80);
    k[90] = 1'b1; key_status = k; run(130);
    check("rr_key3", 64'(vk(3)), 64'd90);
    k[100] = 1'b1; key_status = k; run(130);
    check("rr_key0", 64'(vk(0)), 64'd100);
    check("rr_active", 64'(voice_active), 64'hF);
    check_pulses("rr", 1, 1, 1, 1, 4);

    // Reset mid-play with keys 5 and 6 held: cleared, then re-triggered
    // exactly one cycle after the scan reaches each key.
    @(negedge clk25);
    k = '0; k[5] = 1'b1; k[6] = 1'b1; key_status = k;
    rst = 1'b1;
    run(1);
    check("mid_rst_active", 64'(voice_active), 64'h0);
    check("mid_rst_key",    64'(voice_key),    64'h0);
    check("mid_rst_trig",   64'(voice_trig),   64'h0);
    rst = 1'b0;
    snap();
    run(5);
    check("mid_pre_active", 64'(voice_active), 64'h0);
    run(1);
    check("mid_v0_active", 64'(voice_active), 64'h1);
    check("mid_v0_key",    64'(vk(0)),        64'd5);
    check("mid_v0_trig",   64'(voice_trig),   64'h1);
    run(1);
    check("mid_v1_active", 64'(voice_active), 64'h3);
    check("mid_v1_key",    64'(vk(1)),        64'd6);
    check("mid_v1_trig",   64'(voice_trig),   64'h2);
    run(130);
    check_pulses("mid", 1, 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/voice_alloc.md
VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 Parameter NKEYS, default `NKEYS (128), is the width of the key-status vector.
REQ-002 Parameter NVOICES, default 4, is the number of oscillator voices shared among keys.
REQ-003 Parameter KW, default 7, is the key index width and SHALL equal clog2(NKEYS).
REQ-004 Port clk25, input, 1 bit: the single 25 MHz clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port key_status, input, NKEYS bits: held-key vector from the MIDI interface; bit k = 1 means key k is down.
REQ-007 Port voice_active, output, NVOICES bits: bit v = 1 means voice v is sounding a held key (gate).
REQ-008 Port voice_key, output, NVOICES*KW bits: slice [v*KW +: KW] is the key number assigned to voice v.
REQ-009 Port voice_trig, output, NVOICES bits: one-cycle pulse on bit v when voice v is (re)assigned.
REQ-010 Port steal, output, 1 bit: one-cycle pulse when an allocation evicts a sounding voice.

Function
REQ-011 A scan counter scan_idx (KW bits) SHALL increment by 1 every cycle and wrap from NKEYS-1 to 0.
REQ-012 A snapshot register prev_status (NKEYS bits) SHALL record the last examined value of each key bit.
- Updated as prev_status[scan_idx] <= key_status[scan_idx] each cycle.
REQ-013 Note-on SHALL be detected in the cycle where key_status[scan_idx]=1 and prev_status[scan_idx]=0.
REQ-014 Note-off SHALL be detected in the cycle where key_status[scan_idx]=0 and prev_status[scan_idx]=1.
REQ-015 Only the key at scan_idx SHALL be evaluated per cycle, so at most one event occurs per cycle.
REQ-016 On note-on with at least one inactive voice, the block SHALL allocate the lowest-numbered inactive voice v, registered at the next edge.
- voice_active[v] <= 1.
- voice_key[v] <= scan_idx.
- voice_trig[v] <= 1.
REQ-017 On note-on with all voices active, the block SHALL evict voice steal_ptr at the next edge.
- voice_key[steal_ptr] <= scan_idx.
- voice_trig[steal_ptr] <= 1; steal <= 1.
- steal_ptr <= (steal_ptr+1) mod NVOICES.
- voice_active stays 1.
REQ-018 steal_ptr SHALL change only on a steal event.
REQ-019 On note-off, any active voice v with voice_key[v]==scan_idx SHALL clear voice_active[v] at the next edge.
- voice_key[v] retains its value so the release envelope keeps its pitch.
REQ-020 A note-off matching no active voice (previously stolen key) SHALL be ignored, with no output change.
REQ-021 voice_trig and steal SHALL be 0 in every cycle not immediately following an allocation event.
REQ-022 Latency from a key_status change to the output update SHALL be at most NKEYS+1 cycles, and exactly 1 cycle after scan_idx reaches that key.
REQ-023 A key that toggles and returns to its old value between two visits of scan_idx SHALL produce no event.
REQ-024 No two active voices SHALL ever hold the same key number.
REQ-025 Combinational logic SHALL drive no output; all outputs are registered.

Reset
REQ-026 While rst=1 at a clock edge, the following SHALL become 0 at that edge: scan_idx, steal_ptr, prev_status, voice_active, voice_key, voice_trig and steal.
REQ-027 Reset asserted mid-operation SHALL discard all assignments, and keys still held SHALL re-trigger as note-ons on the first scan after rst deasserts.
REQ-028 Scanning SHALL start at index 0 in the first cycle after rst deasserts.

Verification
REQ-029 Reset: hold rst for 2 cycles with key_status random -> all outputs 0 and scan_idx=0 in the cycle after deassertion.
REQ-030 Single note: set key 60 -> within 129 cycles voice_active=0001, voice_key[0]=60, voice_trig=0001 for exactly 1 cycle, steal never 1.
REQ-031 Chord: set keys 67, 64 and 60 together -> voices 0/1/2 get 60/64/67 in scan order, voice_active=0111, three separate trig pulses.
REQ-032 Steal: hold keys 10, 20, 30, 40 and then add key 50 -> voice_key[0]=50, trig[0] and steal pulse once, steal_ptr=1; releasing key 10 -> no output change.
REQ-033 Release: with key 60 on voice 0, clear key 60 -> voice_active[0]=0 within 129 cycles, voice_key[0] still 60, no trig.
REQ-034 Reset mid-operation: hold keys 5 and 6 and pulse rst -> outputs cleared, then voices 0/1 re-assigned 5/6 with trig pulses within 130 cycles.
